// File: rtl/concat_packer_pkg.sv
// Shared constants and width helpers for the concat_packer bit-field packer.
package concat_packer_pkg;

   localparam int CONCAT_OUT_W_DEF = 8;
   localparam int CONCAT_IN_W_DEF  = 4;

   // What the output register takes on the next edge, if anything.
   typedef enum logic [1:0] {
      LOAD_NONE,
      LOAD_WORD,
      LOAD_FLUSH
   } load_kind_e;

   function automatic int len_w(input int in_w);
      return $clog2(in_w + 1);
   endfunction

   function automatic int fill_w(input int out_w);
      return $clog2(out_w + 1);
   endfunction

endpackage

// File: rtl/concat_packer_align.sv
// Combinational core: appends a field below the accumulator bits and splits
// off a completed word when the combined length reaches OUT_W.
module concat_packer_align
   import concat_packer_pkg::*;
#(
   parameter int OUT_W = CONCAT_OUT_W_DEF,
   parameter int IN_W  = CONCAT_IN_W_DEF,
   localparam int LW   = len_w(IN_W),
   localparam int FW   = fill_w(OUT_W)
) (
   input  logic [OUT_W-1:0] acc,
   input  logic [FW-1:0]    fill,
   input  logic [IN_W-1:0]  field,
   input  logic [LW-1:0]    len,
   output logic [OUT_W-1:0] acc_next,
   output logic [FW-1:0]    fill_next,
   output logic [OUT_W-1:0] word,
   output logic             word_done,
   output logic [FW-1:0]    residual
);

   localparam int CW = OUT_W + IN_W;
   localparam int TW = FW + 1;

   logic [LW-1:0] len_c;
   logic [CW-1:0] acc_m;
   logic [CW-1:0] field_m;
   logic [CW-1:0] cat;
   logic [CW-1:0] low_mask;
   logic [TW-1:0] total;

   // The combined bit string always sits right-aligned in cat, so a completed
   // word is simply its top OUT_W valid bits and the residual stays below.
   always_comb begin
      len_c     = (len > LW'(IN_W)) ? LW'(IN_W) : len;
      acc_m     = CW'(acc) & ~({CW{1'b1}} << fill);
      field_m   = CW'(field) & ~({CW{1'b1}} << len_c);
      cat       = (acc_m << len_c) | field_m;
      total     = TW'(fill) + TW'(len_c);
      word_done = (total >= TW'(OUT_W));
      residual  = word_done ? FW'(total - TW'(OUT_W)) : '0;
      low_mask  = ~({CW{1'b1}} << residual);
      word      = OUT_W'(cat >> residual);
      acc_next  = word_done ? OUT_W'(cat & low_mask) : OUT_W'(cat);
      fill_next = word_done ? residual : FW'(total);
   end

endmodule

// File: rtl/concat_packer.sv
// Bit-field packer top: slot/flush control and output register.
// Optional handshake counter enabled by defining CONCAT_PACKER_STATS_EN.
module concat_packer
   import concat_packer_pkg::*;
#(
   parameter int OUT_W = CONCAT_OUT_W_DEF,
   parameter int IN_W  = CONCAT_IN_W_DEF,
   localparam int LW   = len_w(IN_W),
   localparam int FW   = fill_w(OUT_W)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic [LW-1:0]    in_len,
   input  logic             flush,
   output logic             flush_done,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [FW-1:0]    out_len
`ifdef CONCAT_PACKER_STATS_EN
   ,
   output logic [15:0]      words_out
`endif
);

   logic [OUT_W-1:0] acc;
   logic [OUT_W-1:0] acc_next;
   logic [OUT_W-1:0] word;
   logic [OUT_W-1:0] flush_word;
   logic [FW-1:0]    fill;
   logic [FW-1:0]    fill_next;
   logic [FW-1:0]    residual;
   logic             word_done;
   logic             slot_free;
   logic             accept;
   logic             flush_take;
   load_kind_e       load_kind;

   concat_packer_align #(
      .OUT_W(OUT_W),
      .IN_W (IN_W)
   ) u_align (
      .acc      (acc),
      .fill     (fill),
      .field    (in_data),
      .len      (in_len),
      .acc_next (acc_next),
      .fill_next(fill_next),
      .word     (word),
      .word_done(word_done),
      .residual (residual)
   );

   // Flush owns the slot while requested, so a field and a flush never collide.
   always_comb begin
      slot_free  = !out_valid || out_ready;
      in_ready   = slot_free && !flush;
      accept     = in_valid && in_ready;
      flush_take = flush && slot_free;
      flush_word = acc << (FW'(OUT_W) - fill);
      load_kind  = LOAD_NONE;
      if (flush_take && (fill != '0)) begin
         load_kind = LOAD_FLUSH;
      end else if (accept && word_done) begin
         load_kind = LOAD_WORD;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc        <= '0;
         fill       <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_len    <= '0;
         flush_done <= 1'b0;
      end else begin
         flush_done <= flush_take;
         case (load_kind)
            LOAD_FLUSH: begin
               out_data  <= flush_word;
               out_len   <= fill;
               out_valid <= 1'b1;
               acc       <= '0;
               fill      <= '0;
            end
            LOAD_WORD: begin
               out_data  <= word;
               out_len   <= FW'(OUT_W);
               out_valid <= 1'b1;
               acc       <= acc_next;
               fill      <= residual;
            end
            default: begin
               if (accept) begin
                  acc  <= acc_next;
                  fill <= fill_next;
               end
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
               end
            end
         endcase
      end
   end

`ifdef CONCAT_PACKER_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         words_out <= '0;
      end else if (out_valid && out_ready && (words_out != 16'hFFFF)) begin
         words_out <= words_out + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_concat_packer.sv
// Scoreboard bench for concat_packer: a bit-queue reference model predicts
// every output word; a negedge monitor pops and compares on each handshake.
module tb_concat_packer;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic [2:0] in_len;
   logic       flush;
   logic       flush_done;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] out_data;
   logic [3:0] out_len;
`ifdef CONCAT_PACKER_STATS_EN
   logic [15:0] words_out;
   bit          sat_forced = 1'b0;
`endif

   int          total_cnt = 0;
   int          bad_cnt = 0;
   int          ready_mode = 1;
   int          hs_count = 0;
   bit          bitq[$];
   logic [11:0] expq[$];
   logic        exp_fd = 1'b0;
   bit          prev_hold = 1'b0;
   logic [7:0]  prev_data;
   logic [3:0]  prev_len;

   always #5 clk = ~clk;

   concat_packer dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_len    (in_len),
      .flush     (flush),
      .flush_done(flush_done),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_len   (out_len)
`ifdef CONCAT_PACKER_STATS_EN
      ,
      .words_out (words_out)
`endif
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total_cnt++;
      if (actual !== expected) begin
         bad_cnt++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic recordTimeout(input string name);
      total_cnt++;
      bad_cnt++;
      $display("[TB] FAIL %s: got timeout expected handshake at %0t", name, $time);
   endtask

   // Reference model: fields become a plain MSB-first bit stream, chopped into bytes.
   task automatic modelAccept(input int len, input logic [3:0] data);
      int         l;
      logic [7:0] w;
      l = (len > 4) ? 4 : len;
      for (int i = l - 1; i >= 0; i--) bitq.push_back(data[i]);
      if (bitq.size() >= 8) begin
         for (int i = 7; i >= 0; i--) w[i] = bitq.pop_front();
         expq.push_back({4'd8, w});
      end
   endtask

   task automatic modelFlush();
      int         n;
      logic [7:0] w;
      n = bitq.size();
      if (n > 0) begin
         w = 8'h00;
         for (int i = 0; i < n; i++) w[7-i] = bitq.pop_front();
         expq.push_back({4'(n), w});
      end
   endtask

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   // Inputs only change just after posedge, so negedge values are what the next edge sees.
   always @(negedge clk) begin
      if (rst) begin
         bitq.delete();
         expq.delete();
         exp_fd    = 1'b0;
         prev_hold = 1'b0;
         hs_count  = 0;
      end else begin
         logic [11:0] e;
         checkOutput("flush_done", flush_done, exp_fd);
         if (prev_hold) begin
            checkOutput("hold_data", out_data, prev_data);
            checkOutput("hold_len", out_len, prev_len);
         end
         if (out_valid && !out_ready) checkOutput("in_ready_blocked", in_ready, 0);
         if (flush) checkOutput("in_ready_flush", in_ready, 0);
         if (out_valid && out_ready) begin
            hs_count++;
            if (expq.size() == 0) begin
               total_cnt++;
               bad_cnt++;
               $display("[TB] FAIL unexpected_word: got %0h len %0d expected none", out_data, out_len);
            end else begin
               e = expq.pop_front();
               checkOutput("word_data", out_data, e[7:0]);
               checkOutput("word_len", out_len, e[11:8]);
            end
         end
         exp_fd = flush && (!out_valid || out_ready);
         if (exp_fd) modelFlush();
         else if (in_valid && in_ready) modelAccept(in_len, in_data);
         prev_hold = out_valid && !out_ready;
         prev_data = out_data;
         prev_len  = out_len;
      end
   end

   task automatic applyStimulus(input int len, input int data);
      int waited = 0;
      in_valid = 1'b1;
      in_len   = 3'(len);
      in_data  = 4'(data);
      forever begin
         @(negedge clk);
         if (in_ready) break;
         waited++;
         if (waited > 200) begin
            recordTimeout("field_handshake");
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic doFlush();
      int waited = 0;
      @(posedge clk);
      #1;
      flush = 1'b1;
      forever begin
         @(negedge clk);
         if (flush_done) break;
         waited++;
         if (waited > 200) begin
            recordTimeout("flush_done_wait");
            break;
         end
      end
      @(posedge clk);
      #1;
      flush = 1'b0;
   endtask

   task automatic setReady(input int m);
      @(negedge clk);
      ready_mode = m;
      @(posedge clk);
      #1;
   endtask

   task automatic pulseReset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 4'h0;
      in_len   = 3'd0;
      flush    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_out_data", out_data, 0);
      checkOutput("reset_out_len", out_len, 0);
      checkOutput("reset_flush_done", flush_done, 0);
      checkOutput("reset_in_ready", in_ready, 1);
`ifdef CONCAT_PACKER_STATS_EN
      checkOutput("reset_words_out", words_out, 0);
`endif
      @(posedge clk);
      #1;

      applyStimulus(2, 4'b0010);
      applyStimulus(3, 4'b0011);
      applyStimulus(3, 4'b0101);
      checkOutput("pack3_valid", out_valid, 1);
      checkOutput("pack3_data", out_data, 8'b10011101);
      checkOutput("pack3_len", out_len, 8);

      applyStimulus(3, 4'b0111);
      applyStimulus(3, 4'b0000);
      applyStimulus(4, 4'b1011);
      checkOutput("carry_word", out_data, 8'b11100010);
      doFlush();
      checkOutput("flush_data", out_data, 8'b11000000);
      checkOutput("flush_len", out_len, 2);

      setReady(0);
      applyStimulus(3, 4'b0101);
      applyStimulus(3, 4'b0010);
      applyStimulus(4, 4'b1110);
      repeat (5) begin
         @(negedge clk);
         checkOutput("hold_valid", out_valid, 1);
      end
      setReady(1);
      in_valid = 1'b1;
      in_len   = 3'd4;
      in_data  = 4'b1001;
      @(negedge clk);
      checkOutput("same_cycle_accept", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      applyStimulus(2, 4'b0001);

      doFlush();
      checkOutput("empty_flush_no_word", out_valid, 0);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_len   = 3'd4;
      in_data  = 4'hF;
      repeat (2) @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      applyStimulus(4, 4'hA);
      applyStimulus(4, 4'h5);
      checkOutput("after_blocked_field", out_data, 8'hA5);

      setReady(0);
      applyStimulus(3, 4'b0110);
      applyStimulus(3, 4'b0011);
      applyStimulus(4, 4'b0111);
      pulseReset();
      checkOutput("midreset_valid", out_valid, 0);
      checkOutput("midreset_len", out_len, 0);
      setReady(1);
      applyStimulus(4, 4'hF);
      applyStimulus(4, 4'h0);
      checkOutput("post_reset_word", out_data, 8'hF0);

`ifdef CONCAT_PACKER_STATS_EN
      applyStimulus(4, 4'h1);
      applyStimulus(4, 4'h2);
      applyStimulus(4, 4'h3);
      applyStimulus(4, 4'h4);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("words_out_three", words_out, 3);
      force dut.words_out = 16'hFFFF;
      @(posedge clk);
      #1;
      release dut.words_out;
      sat_forced = 1'b1;
      applyStimulus(4, 4'h5);
      applyStimulus(4, 4'h6);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("words_out_saturate", words_out, 16'hFFFF);
`endif

      setReady(2);
      repeat (300) begin
         if ($urandom_range(0, 9) == 0) doFlush();
         else applyStimulus($urandom_range(0, 7), $urandom_range(0, 15));
      end
      setReady(1);
      doFlush();
      repeat (4) @(posedge clk);
      #1;
      checkOutput("scoreboard_empty", expq.size(), 0);
`ifdef CONCAT_PACKER_STATS_EN
      checkOutput("words_out_final", words_out, sat_forced ? 16'hFFFF : hs_count);
`endif

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
